// File: rtl/ifu_exu_ibuf.sv
// Instruction buffer between IFU fetch and EXU execute: a small circular FIFO of {IR, PC}
// entries that absorbs EXU stalls and is emptied by an EXU pipe flush.
module ifu_exu_ibuf #(
    parameter int DEPTH   = 2,
    parameter int XLEN    = 32,
    parameter int PC_SIZE = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic                       ibuf_i_ifu_valid,
    output logic                       ibuf_o_ifu_ready,
    input  logic [XLEN-1:0]            ibuf_i_ir,
    input  logic [PC_SIZE-1:0]         ibuf_i_pc,

    input  logic                       ibuf_i_pipe_flush_req,

    output logic                       ibuf_o_exu_valid,
    input  logic                       ibuf_i_exu_ready,
    output logic [XLEN-1:0]            ibuf_o_ir,
    output logic [PC_SIZE-1:0]         ibuf_o_pc,
    output logic                       ibuf_o_rv32,

    output logic [$clog2(DEPTH):0]     ibuf_o_count,
    output logic                       ibuf_o_empty,
    output logic                       ibuf_o_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [XLEN-1:0]    ir_mem [DEPTH];
    logic [PC_SIZE-1:0] pc_mem [DEPTH];

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic               empty;
    logic               full;
    logic               push;
    logic               pop;
    logic               flush;

    logic [PTR_W-1:0]   wr_ptr_nxt;
    logic [PTR_W-1:0]   rd_ptr_nxt;
    logic [CNT_W-1:0]   count_nxt;

    // Status is decoded from the registered count only, so EXU valid has no input path.
    assign flush = ibuf_i_pipe_flush_req;
    assign empty = (count == '0);
    assign full  = (count == CNT_MAX);

    assign ibuf_o_ifu_ready = !full && !flush;
    assign ibuf_o_exu_valid = !empty;

    assign push = ibuf_i_ifu_valid && ibuf_o_ifu_ready;
    assign pop  = ibuf_o_exu_valid && ibuf_i_exu_ready && !flush;

    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            count_nxt  = '0;
        end else if (push && pop) begin
            wr_ptr_nxt = wr_ptr + PTR_W'(1);
            rd_ptr_nxt = rd_ptr + PTR_W'(1);
        end else if (push) begin
            wr_ptr_nxt = wr_ptr + PTR_W'(1);
            count_nxt  = count + CNT_W'(1);
        end else if (pop) begin
            rd_ptr_nxt = rd_ptr + PTR_W'(1);
            count_nxt  = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
        end
    end

    // Storage is cleared on reset so the head outputs read zero until the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ir_mem[i] <= '0;
                pc_mem[i] <= '0;
            end
        end else if (push) begin
            ir_mem[wr_ptr] <= ibuf_i_ir;
            pc_mem[wr_ptr] <= ibuf_i_pc;
        end
    end

    assign ibuf_o_ir    = ir_mem[rd_ptr];
    assign ibuf_o_pc    = pc_mem[rd_ptr];
    assign ibuf_o_rv32  = (ibuf_o_ir[1:0] == 2'b11);
    assign ibuf_o_count = count;
    assign ibuf_o_empty = empty;
    assign ibuf_o_full  = full;

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= CNT_MAX);
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) push |-> !full);
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) pop |-> !empty);

endmodule

// File: tb/tb_ifu_exu_ibuf.sv
// Directed self-checking bench for ifu_exu_ibuf (DEPTH=2): reset, latency, full/hold,
// streaming across pointer wrap, flush while full, 16-bit detect and async reset mid-stream.
module tb_ifu_exu_ibuf;

    logic        clk;
    logic        rst_n;
    logic        ifuValid;
    logic        ifuReady;
    logic [31:0] inIr;
    logic [31:0] inPc;
    logic        flushReq;
    logic        exuValid;
    logic        exuReady;
    logic [31:0] outIr;
    logic [31:0] outPc;
    logic        outRv32;
    logic [1:0]  outCount;
    logic        outEmpty;
    logic        outFull;

    int compareCount  = 0;
    int mismatchCount = 0;

    ifu_exu_ibuf #(.DEPTH(2), .XLEN(32), .PC_SIZE(32)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .ibuf_i_ifu_valid      (ifuValid),
        .ibuf_o_ifu_ready      (ifuReady),
        .ibuf_i_ir             (inIr),
        .ibuf_i_pc             (inPc),
        .ibuf_i_pipe_flush_req (flushReq),
        .ibuf_o_exu_valid      (exuValid),
        .ibuf_i_exu_ready      (exuReady),
        .ibuf_o_ir             (outIr),
        .ibuf_o_pc             (outPc),
        .ibuf_o_rv32           (outRv32),
        .ibuf_o_count          (outCount),
        .ibuf_o_empty          (outEmpty),
        .ibuf_o_full           (outFull)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Inputs change on the falling edge, well away from the sampling rising edge.
    task automatic applyStimulus(input logic v, input logic [31:0] ir, input logic [31:0] pc,
                                 input logic er, input logic fl);
        @(negedge clk);
        ifuValid = v;
        inIr     = ir;
        inPc     = pc;
        exuReady = er;
        flushReq = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        ifuValid = 1'b0;
        inIr     = '0;
        inPc     = '0;
        exuReady = 1'b0;
        flushReq = 1'b0;
        #12;

        // Reset values
        checkOutput("rst_exu_valid", exuValid, 0);
        checkOutput("rst_empty",     outEmpty, 1);
        checkOutput("rst_full",      outFull, 0);
        checkOutput("rst_ifu_ready", ifuReady, 1);
        checkOutput("rst_ir",        outIr, 0);
        checkOutput("rst_pc",        outPc, 0);
        checkOutput("rst_rv32",      outRv32, 0);
        checkOutput("rst_count",     outCount, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single push, one-cycle latency, then popped
        applyStimulus(1, 32'h00000013, 32'h80000000, 1, 0);
        tick();
        checkOutput("t1_valid", exuValid, 1);
        checkOutput("t1_ir",    outIr, 32'h13);
        checkOutput("t1_pc",    outPc, 32'h80000000);
        checkOutput("t1_rv32",  outRv32, 1);
        checkOutput("t1_count", outCount, 1);
        applyStimulus(0, 0, 0, 1, 0);
        tick();
        checkOutput("t1_empty_after_pop", outEmpty, 1);
        checkOutput("t1_valid_after_pop", exuValid, 0);

        // 2: fill with EXU stalled, third instruction held until room
        applyStimulus(1, 32'h00100093, 32'h100, 0, 0);
        tick();
        checkOutput("t2_count1", outCount, 1);
        applyStimulus(1, 32'h00200113, 32'h104, 0, 0);
        tick();
        checkOutput("t2_count2", outCount, 2);
        checkOutput("t2_full",   outFull, 1);
        applyStimulus(1, 32'h00300193, 32'h108, 0, 0);
        tick();
        checkOutput("t2_held_count", outCount, 2);
        checkOutput("t2_held_ready", ifuReady, 0);
        checkOutput("t2_head_a",     outPc, 32'h100);
        applyStimulus(1, 32'h00300193, 32'h108, 1, 0);
        #1;
        checkOutput("t2_no_pop_through", ifuReady, 0);
        tick();
        checkOutput("t2_after_pop_count", outCount, 1);
        checkOutput("t2_head_b",          outPc, 32'h104);
        checkOutput("t2_ready_again",     ifuReady, 1);
        applyStimulus(1, 32'h00300193, 32'h108, 1, 0);
        tick();
        checkOutput("t2_pushpop_count", outCount, 1);
        checkOutput("t2_head_c",        outPc, 32'h108);
        checkOutput("t2_head_c_ir",     outIr, 32'h00300193);
        applyStimulus(0, 0, 0, 1, 0);
        tick();
        checkOutput("t2_drained", outEmpty, 1);

        // 3: streaming push/pop across pointer wrap
        applyStimulus(1, 32'h00000013, 32'h0, 1, 0);
        tick();
        checkOutput("t3_prime_pc", outPc, 32'h0);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1, 32'h00000013, 32'(4 * i), 1, 0);
            tick();
            checkOutput($sformatf("t3_count_%0d", i), outCount, 1);
            checkOutput($sformatf("t3_pc_%0d", i), outPc, 64'(4 * i));
        end
        applyStimulus(0, 0, 0, 1, 0);
        tick();
        checkOutput("t3_drained", outEmpty, 1);

        // 4: flush while full with valid and ready both asserted
        applyStimulus(1, 32'h00000013, 32'h200, 0, 0);
        tick();
        applyStimulus(1, 32'h00000013, 32'h204, 0, 0);
        tick();
        checkOutput("t4_full", outFull, 1);
        applyStimulus(1, 32'h00000013, 32'h208, 1, 1);
        #1;
        checkOutput("t4_ready_during_flush", ifuReady, 0);
        tick();
        checkOutput("t4_count", outCount, 0);
        checkOutput("t4_valid", exuValid, 0);
        applyStimulus(0, 0, 0, 1, 0);
        #1;
        checkOutput("t4_ready_after", ifuReady, 1);
        applyStimulus(1, 32'h00000033, 32'h20c, 0, 0);
        tick();
        checkOutput("t4_post_flush_pc", outPc, 32'h20c);
        applyStimulus(0, 0, 0, 1, 0);
        tick();
        checkOutput("t4_post_flush_empty", outEmpty, 1);

        // 5: 16-bit detect, then asynchronous reset with two entries buffered
        applyStimulus(1, 32'h00004501, 32'h300, 0, 0);
        tick();
        checkOutput("t5_rv32", outRv32, 0);
        checkOutput("t5_ir",   outIr, 32'h00004501);
        applyStimulus(1, 32'h00000013, 32'h302, 0, 0);
        tick();
        checkOutput("t5_count2", outCount, 2);
        applyStimulus(0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_count", outCount, 0);
        checkOutput("t5_rst_valid", exuValid, 0);
        checkOutput("t5_rst_empty", outEmpty, 1);
        checkOutput("t5_rst_ir",    outIr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 32'h00000033, 32'h400, 0, 0);
        tick();
        checkOutput("t5_after_rst_pc",    outPc, 32'h400);
        checkOutput("t5_after_rst_count", outCount, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
